// File: rtl/uart_hex_loader.sv
// -----------------------------------------------------------------------------
// uart_hex_loader
//   Parses an ASCII hex load stream coming out of uart_rx and writes the
//   decoded bytes into CPU program memory. The CPU is held halted from 'L'
//   until 'G', which releases it with a one-cycle start pulse.
//
//   Protocol (after 'L'):  hex pairs are data bytes written at an
//   auto-incrementing address; '@hh' sets the address; space/CR/LF/','
//   are ignored; 'L' restarts at address 0 and clears err; 'G' runs.
//
// Optional feature macro: UART_LOADER_ECHO_EN
//   When defined, every accepted byte is echoed on tx_data/tx_data_valid and
//   further rx bytes are held off until the echo is taken. When undefined,
//   the tx outputs are tied to 0 and tx_data_ready is ignored.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data/_valid/_ready    byte stream from uart_rx (ready = 1-cycle pulse)
//   mem_we/mem_addr/mem_wdata program memory write port
//   cpu_halt, cpu_start      CPU run control
//   err                      sticky protocol error, cleared by 'L'
//   tx_data/_valid/_ready    echo stream (echo build only)
// -----------------------------------------------------------------------------
module uart_hex_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              err,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_AHI,
    S_ALO
  } state_t;

  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          hi_q, hi_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                start_q, start_d;
  logic                halt_q, halt_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;
  // Set once a byte is taken; cleared only when valid drops, so a source
  // that keeps valid high after the ready pulse cannot get its byte
  // consumed twice.
  logic                consumed_q, consumed_d;
  logic [7:0]          tx_q, tx_d;
  logic                txv_q, txv_d;

  logic                echo_busy;
  logic                accept;
  logic [4:0]          hd;
  logic                hx;
  logic [3:0]          nib;
  logic [7:0]          byte_v;
  logic                is_l, is_g;

`ifdef UART_LOADER_ECHO_EN
  assign echo_busy = txv_q;
`else
  assign echo_busy = 1'b0;
  logic unused_tx_ready;
  assign unused_tx_ready = tx_data_ready;
`endif

  assign accept = rx_data_valid && !rdy_q && !consumed_q && !echo_busy;
  assign hd     = hex_dec(rx_data);
  assign hx     = hd[4];
  assign nib    = hd[3:0];
  assign byte_v = {hi_q, nib};
  assign is_l   = (rx_data == 8'h4C) || (rx_data == 8'h6C);
  assign is_g   = (rx_data == 8'h47) || (rx_data == 8'h67);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    start_d    = 1'b0;
    halt_d     = halt_q;
    err_d      = err_q;
    rdy_d      = 1'b0;
    consumed_d = consumed_q;
    tx_d       = tx_q;
    txv_d      = txv_q;

    // Address advances on the cycle after the strobe so mem_addr stays
    // stable for the whole write. The ready pulse coincides with the
    // strobe, so no byte can be accepted in the same cycle.
    if (we_q) addr_d = addr_q + 1'b1;

    if (!rx_data_valid) consumed_d = 1'b0;

`ifdef UART_LOADER_ECHO_EN
    if (txv_q && tx_data_ready) txv_d = 1'b0;
`endif

    if (accept) begin
      rdy_d      = 1'b1;
      consumed_d = 1'b1;
`ifdef UART_LOADER_ECHO_EN
      tx_d  = rx_data;
      txv_d = 1'b1;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (is_l) begin
            state_d = S_HI;
            addr_d  = '0;
            err_d   = 1'b0;
            halt_d  = 1'b1;
          end
        end
        S_HI: begin
          if (hx) begin
            hi_d    = nib;
            state_d = S_LO;
          end else if (is_ws(rx_data)) begin
            state_d = S_HI;
          end else if (rx_data == 8'h40) begin
            state_d = S_AHI;
          end else if (is_g) begin
            start_d = 1'b1;
            halt_d  = 1'b0;
            state_d = S_IDLE;
          end else if (is_l) begin
            addr_d = '0;
            err_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_LO: begin
          if (hx) begin
            we_d    = 1'b1;
            wdata_d = byte_v;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_HI;
        end
        S_AHI: begin
          if (hx) begin
            hi_d    = nib;
            state_d = S_ALO;
          end else begin
            err_d   = 1'b1;
            state_d = S_HI;
          end
        end
        S_ALO: begin
          if (hx) addr_d = ADDR_W'(byte_v);
          else    err_d  = 1'b1;
          state_d = S_HI;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      hi_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      consumed_q <= 1'b0;
      tx_q       <= '0;
      txv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      start_q    <= start_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      consumed_q <= consumed_d;
      tx_q       <= tx_d;
      txv_q      <= txv_d;
    end
  end

  assign rx_data_ready = rdy_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_halt      = halt_q;
  assign cpu_start     = start_q;
  assign err           = err_q;
  assign tx_data       = tx_q;
  assign tx_data_valid = txv_q;

endmodule
